ca_row: RTL and testbench
=========================

# ca_row

Parametrised one-dimensional cellular-automaton row: WIDTH processing cells updated in lock-step under an 8-bit Wolfram rule. A small control FSM loads a seed, advances a programmable number of generations on a tick strobe, then reports completion. The block sits between the lab's switch/button front end and the LED/VGA display path, and generalises the single-cell element to a full row with boundary modes and run control.

## Interface

- WIDTH, 16: number of cells (≥ 3)
- GEN_W, 8: width of the generation target and counter

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rule  in  8  Wolfram rule, latched on accepted start
- wrapMode  in  1  1 = toroidal boundary, 0 = fixed-zero boundary; latched on accepted start
- initialState  in  WIDTH  seed row, sampled on accepted start
- genTarget  in  GEN_W  generations to run, latched on accepted start
- start  in  1  single-cycle request to load and run
- tick  in  1  generation-advance strobe (from the clock divider)
- abort  in  1  stop the run and return to IDLE
- currentState  out  WIDTH  present row, bit WIDTH-1 leftmost
- genCount  out  GEN_W  generations completed since last load
- busy  out  1  high in RUN
- done  out  1  high in DONE
- stable  out  1  only with CA_STUCK_DETECT_EN: fixed point reached

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: start → latch rule/wrapMode/genTarget, currentState ← initialState, genCount ← 0; next state RUN, or DONE if genTarget = 0.
- RUN: tick → currentState ← next row, genCount + 1; when the incremented count equals the latched target → DONE. Ticks outside RUN are ignored.
- DONE: holds row and count; start reloads exactly as from IDLE.
- abort in RUN or DONE → IDLE; row and genCount hold. abort beats start and tick in the same cycle.
- start while in RUN is ignored.
- Next row, per cell i: next[i] = ruleLatched[{L, row[i], R}], with L = row[i+1] and R = row[i-1].
- Boundary for wrapMode = 1: row[WIDTH] ≡ row[0] and row[-1] ≡ row[WIDTH-1].
- Boundary for wrapMode = 0: out-of-range neighbours read 0.
- genCount never wraps: the target comparison stops it at genTarget.

## Timing

- Reset values: currentState = 0, genCount = 0, busy = 0, done = 0, stable = 0, FSM = IDLE. Latched rule/mode/target also clear to 0.
- start is accepted on clock edge k. From edge k: currentState shows the seed, and busy or done is high.
- Each accepted tick updates the row on that edge, giving one cycle of latency.
- done rises on the edge of the final tick and stays high until start or abort.
- Reset asserted mid-run forces every output to its reset value immediately, independent of clk.

## Configuration

- CA_STUCK_DETECT_EN defined: on each RUN tick, compare next row with current row. If they are equal, apply the update, set stable = 1, and enter DONE early with genCount incremented. stable clears on start, abort or reset.
- CA_STUCK_DETECT_EN undefined: no comparator and no stable port. The run always lasts genTarget ticks.

## Structure

- Shared package ca_pkg holds:
  - FSM state typedef
  - RULE_W = 8
  - boundary-mode constants
- One sub-module, ca_cell, generated WIDTH times. Each instance is a combinational rule lookup from 3 neighbourhood bits and the 8-bit rule to the next-state bit. Row registers, FSM and counter live in ca_row.

## Test plan

- WIDTH=8, rule 90, wrapMode 0, seed 8'b00010000, target 1: start, one tick → currentState 8'b00101000, genCount 1, done 1.
- Rule 90, seed 8'b00000001, target 1, one tick: wrapMode 1 → 8'b10000010; wrapMode 0 → 8'b00000010.
- genTarget 0: start → done on the same edge, busy never high, row = seed.
- Rule 30, target 5, abort asserted together with the 3rd tick → IDLE, genCount 2. Further ticks change nothing.
- Reset dropped mid-run at generation 3 → all outputs 0 asynchronously. After release, start behaves normally.
- Rule 204 (identity), target 10: with CA_STUCK_DETECT_EN → done and stable after the first tick, genCount 1. Without it → done after 10 ticks, genCount 10.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and constants for the ca_row cellular-automaton block.
// Optional feature macro used by this slice: CA_STUCK_DETECT_EN.
package ca_pkg;

  localparam int RULE_W = 8;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_WRAP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ca_state_e;

  // Wolfram lookup: neighbourhood {L, C, R} selects one bit of the rule
  function automatic logic ca_lookup(input logic [RULE_W-1:0] rule, input logic [2:0] nbhd);
    logic bit_v;
    case (nbhd)
      3'd0:    bit_v = rule[0];
      3'd1:    bit_v = rule[1];
      3'd2:    bit_v = rule[2];
      3'd3:    bit_v = rule[3];
      3'd4:    bit_v = rule[4];
      3'd5:    bit_v = rule[5];
      3'd6:    bit_v = rule[6];
      3'd7:    bit_v = rule[7];
      default: bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/ca_cell.sv
// Single automaton cell: combinational rule lookup from its 3-bit neighbourhood.
module ca_cell
  import ca_pkg::*;
(
  input  logic [RULE_W-1:0] rule,
  input  logic              nbr_left,
  input  logic              center,
  input  logic              nbr_right,
  output logic              next_bit
);

  logic [2:0] nbhd_s;

  // Rule lookup for this cell
  always_comb begin
    nbhd_s   = {nbr_left, center, nbr_right};
    next_bit = ca_lookup(rule, nbhd_s);
  end

endmodule

// File: rtl/ca_row.sv
// WIDTH-cell automaton row with load/run/done control and boundary modes.
// Optional stuck (fixed-point) detection when CA_STUCK_DETECT_EN is defined.
module ca_row
  import ca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RULE_W-1:0] rule,
  input  logic              wrapMode,
  input  logic [WIDTH-1:0]  initialState,
  input  logic [GEN_W-1:0]  genTarget,
  input  logic              start,
  input  logic              tick,
  input  logic              abort,
  output logic [WIDTH-1:0]  currentState,
  output logic [GEN_W-1:0]  genCount,
  output logic              busy,
  output logic              done
`ifdef CA_STUCK_DETECT_EN
  ,
  output logic              stable
`endif
);

  ca_state_e         state_r;
  ca_state_e         state_nxt_s;
  logic [RULE_W-1:0] rule_r;
  logic              wrap_r;
  logic [GEN_W-1:0]  target_r;
  logic [GEN_W-1:0]  gen_r;
  logic [GEN_W-1:0]  gen_inc_s;
  logic [WIDTH-1:0]  row_r;
  logic [WIDTH-1:0]  next_row_s;
  logic [WIDTH-1:0]  left_s;
  logic [WIDTH-1:0]  right_s;
  logic              busy_r;
  logic              done_r;
  logic              load_s;
  logic              advance_s;
  logic              abort_s;
  logic              tgt_zero_s;

  // Edge cells see either the opposite end (torus) or a constant zero
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i == WIDTH - 1) begin : g_left_edge
      assign left_s[i] = (wrap_r == MODE_WRAP) ? row_r[0] : 1'b0;
    end else begin : g_left_inner
      assign left_s[i] = row_r[i+1];
    end

    if (i == 0) begin : g_right_edge
      assign right_s[i] = (wrap_r == MODE_WRAP) ? row_r[WIDTH-1] : 1'b0;
    end else begin : g_right_inner
      assign right_s[i] = row_r[i-1];
    end

    ca_cell u_cell (
      .rule      (rule_r),
      .nbr_left  (left_s[i]),
      .center    (row_r[i]),
      .nbr_right (right_s[i]),
      .next_bit  (next_row_s[i])
    );
  end

  assign gen_inc_s  = gen_r + {{(GEN_W-1){1'b0}}, 1'b1};
  assign tgt_zero_s = (genTarget == {GEN_W{1'b0}});

`ifdef CA_STUCK_DETECT_EN
  logic stuck_s;
  logic stable_r;
  assign stuck_s = (next_row_s == row_r);
`endif

  // Next-state decode; abort takes priority over start and tick
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    advance_s   = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          load_s      = 1'b1;
          state_nxt_s = tgt_zero_s ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (tick) begin
          advance_s = 1'b1;
          if (gen_inc_s == target_r) begin
            state_nxt_s = ST_DONE;
          end
`ifdef CA_STUCK_DETECT_EN
          else if (stuck_s) begin
            state_nxt_s = ST_DONE;
          end
`endif
          else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (abort) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          load_s      = 1'b1;
          state_nxt_s = tgt_zero_s ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Run configuration, captured only when a start is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rule_r   <= {RULE_W{1'b0}};
      wrap_r   <= 1'b0;
      target_r <= {GEN_W{1'b0}};
    end else if (load_s) begin
      rule_r   <= rule;
      wrap_r   <= wrapMode;
      target_r <= genTarget;
    end else begin
      rule_r   <= rule_r;
      wrap_r   <= wrap_r;
      target_r <= target_r;
    end
  end

  // Row and generation counter; both simply hold on abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_r <= {WIDTH{1'b0}};
      gen_r <= {GEN_W{1'b0}};
    end else if (load_s) begin
      row_r <= initialState;
      gen_r <= {GEN_W{1'b0}};
    end else if (advance_s) begin
      row_r <= next_row_s;
      gen_r <= gen_inc_s;
    end else begin
      row_r <= row_r;
      gen_r <= gen_r;
    end
  end

`ifdef CA_STUCK_DETECT_EN
  // Fixed-point flag: set by a no-change tick, cleared by start or abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_r <= 1'b0;
    end else if (load_s || abort_s) begin
      stable_r <= 1'b0;
    end else if (advance_s && stuck_s) begin
      stable_r <= 1'b1;
    end else begin
      stable_r <= stable_r;
    end
  end

  assign stable = stable_r;
`endif

  assign currentState = row_r;
  assign genCount     = gen_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_ca_row.sv
// Directed scoreboard bench for ca_row (WIDTH=8); honours CA_STUCK_DETECT_EN.
module tb_ca_row;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rule;
  logic       wrapMode;
  logic [7:0] initialState;
  logic [7:0] genTarget;
  logic       start;
  logic       tick;
  logic       abort;
  logic [7:0] currentState;
  logic [7:0] genCount;
  logic       busy;
  logic       done;
`ifdef CA_STUCK_DETECT_EN
  logic       stable;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] row;
    logic [7:0] gen;
    logic       busy;
    logic       done;
    logic       stable;
  } exp_t;

  exp_t sb_q[$];
  logic [7:0] m_row;

  ca_row #(.WIDTH(8), .GEN_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rule         (rule),
    .wrapMode     (wrapMode),
    .initialState (initialState),
    .genTarget    (genTarget),
    .start        (start),
    .tick         (tick),
    .abort        (abort),
    .currentState (currentState),
    .genCount     (genCount),
    .busy         (busy),
    .done         (done)
`ifdef CA_STUCK_DETECT_EN
    ,
    .stable       (stable)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ca_next(input logic [7:0] r, input logic w, input logic [7:0] row);
    logic [7:0] lft;
    logic [7:0] rgt;
    logic [7:0] res;
    lft = {w & row[0], row[7:1]};
    rgt = {row[6:0], w & row[7]};
    for (int i = 0; i < 8; i++) res[i] = r[{lft[i], row[i], rgt[i]}];
    return res;
  endfunction

  task automatic push_exp(input string tag, input logic [7:0] erow, input logic [7:0] egen,
                          input logic eb, input logic ed, input logic est);
    exp_t e;
    e.tag = tag; e.row = erow; e.gen = egen; e.busy = eb; e.done = ed; e.stable = est;
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb_q.pop_front();
    n_tests++;
    assert (currentState === e.row) else begin
      n_fail++; $error("FAIL %s row: got %b expected %b", e.tag, currentState, e.row);
    end
    n_tests++;
    assert (genCount === e.gen) else begin
      n_fail++; $error("FAIL %s gen: got %0d expected %0d", e.tag, genCount, e.gen);
    end
    n_tests++;
    assert (busy === e.busy) else begin
      n_fail++; $error("FAIL %s busy: got %b expected %b", e.tag, busy, e.busy);
    end
    n_tests++;
    assert (done === e.done) else begin
      n_fail++; $error("FAIL %s done: got %b expected %b", e.tag, done, e.done);
    end
`ifdef CA_STUCK_DETECT_EN
    n_tests++;
    assert (stable === e.stable) else begin
      n_fail++; $error("FAIL %s stable: got %b expected %b", e.tag, stable, e.stable);
    end
`endif
  endtask

  // Drive one cycle of control strobes, then compare after the edge
  task automatic step(input string tag, input logic s, input logic t, input logic a,
                      input logic [7:0] erow, input logic [7:0] egen,
                      input logic eb, input logic ed, input logic est);
    start = s; tick = t; abort = a;
    push_exp(tag, erow, egen, eb, ed, est);
    @(posedge clk);
    #1;
    start = 1'b0; tick = 1'b0; abort = 1'b0;
    check_pop();
  endtask

  task automatic check_now(input string tag, input logic [7:0] erow, input logic [7:0] egen,
                           input logic eb, input logic ed, input logic est);
    push_exp(tag, erow, egen, eb, ed, est);
    check_pop();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; tick = 1'b0; abort = 1'b0;
    rule = 8'd0; wrapMode = 1'b0; initialState = 8'd0; genTarget = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("idle_tick", 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);

    // rule 90, fixed boundary, single generation
    rule = 8'd90; wrapMode = 1'b0; initialState = 8'b00010000; genTarget = 8'd1;
    step("r90_load", 1'b1, 1'b0, 1'b0, 8'b00010000, 8'd0, 1'b1, 1'b0, 1'b0);
    rule = 8'd0; initialState = 8'hFF; genTarget = 8'd77;
    step("r90_tick", 1'b0, 1'b1, 1'b0, 8'b00101000, 8'd1, 1'b0, 1'b1, 1'b0);
    step("done_tick", 1'b0, 1'b1, 1'b0, 8'b00101000, 8'd1, 1'b0, 1'b1, 1'b0);

    // boundary modes, reloading straight from DONE
    rule = 8'd90; wrapMode = 1'b1; initialState = 8'b00000001; genTarget = 8'd1;
    step("wrap_load", 1'b1, 1'b0, 1'b0, 8'b00000001, 8'd0, 1'b1, 1'b0, 1'b0);
    step("wrap_tick", 1'b0, 1'b1, 1'b0, 8'b10000010, 8'd1, 1'b0, 1'b1, 1'b0);
    wrapMode = 1'b0;
    step("fix_load", 1'b1, 1'b0, 1'b0, 8'b00000001, 8'd0, 1'b1, 1'b0, 1'b0);
    step("fix_tick", 1'b0, 1'b1, 1'b0, 8'b00000010, 8'd1, 1'b0, 1'b1, 1'b0);

    // zero target completes on the load edge
    initialState = 8'hA5; genTarget = 8'd0;
    step("t0_load", 1'b1, 1'b0, 1'b0, 8'hA5, 8'd0, 1'b0, 1'b1, 1'b0);
    step("t0_hold", 1'b0, 1'b0, 1'b0, 8'hA5, 8'd0, 1'b0, 1'b1, 1'b0);

    // rule 30, abort together with the third tick
    rule = 8'd30; wrapMode = 1'b0; initialState = 8'h08; genTarget = 8'd5; m_row = 8'h08;
    step("r30_load", 1'b1, 1'b0, 1'b0, m_row, 8'd0, 1'b1, 1'b0, 1'b0);
    m_row = ca_next(8'd30, 1'b0, m_row);
    step("r30_t1", 1'b0, 1'b1, 1'b0, m_row, 8'd1, 1'b1, 1'b0, 1'b0);
    step("r30_gap", 1'b0, 1'b0, 1'b0, m_row, 8'd1, 1'b1, 1'b0, 1'b0);
    initialState = 8'hFF;
    step("start_in_run", 1'b1, 1'b0, 1'b0, m_row, 8'd1, 1'b1, 1'b0, 1'b0);
    m_row = ca_next(8'd30, 1'b0, m_row);
    step("r30_t2", 1'b0, 1'b1, 1'b0, m_row, 8'd2, 1'b1, 1'b0, 1'b0);
    step("r30_abort", 1'b0, 1'b1, 1'b1, m_row, 8'd2, 1'b0, 1'b0, 1'b0);
    step("r30_after1", 1'b0, 1'b1, 1'b0, m_row, 8'd2, 1'b0, 1'b0, 1'b0);
    step("r30_after2", 1'b0, 1'b1, 1'b0, m_row, 8'd2, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a run
    rule = 8'd110; wrapMode = 1'b1; initialState = 8'h01; genTarget = 8'd8; m_row = 8'h01;
    step("r110_load", 1'b1, 1'b0, 1'b0, m_row, 8'd0, 1'b1, 1'b0, 1'b0);
    for (int g = 1; g <= 3; g++) begin
      m_row = ca_next(8'd110, 1'b1, m_row);
      step("r110_tick", 1'b0, 1'b1, 1'b0, m_row, g[7:0], 1'b1, 1'b0, 1'b0);
    end
    #2 reset = 1'b0;
    #1 check_now("async_reset", 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_now("reset_held", 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    rule = 8'd90; wrapMode = 1'b0; initialState = 8'h10; genTarget = 8'd2; m_row = 8'h10;
    step("post_load", 1'b1, 1'b0, 1'b0, m_row, 8'd0, 1'b1, 1'b0, 1'b0);
    m_row = ca_next(8'd90, 1'b0, m_row);
    step("post_t1", 1'b0, 1'b1, 1'b0, m_row, 8'd1, 1'b1, 1'b0, 1'b0);
    m_row = ca_next(8'd90, 1'b0, m_row);
    step("post_t2", 1'b0, 1'b1, 1'b0, m_row, 8'd2, 1'b0, 1'b1, 1'b0);

    // identity rule: fixed point from the first generation
    rule = 8'd204; wrapMode = 1'b1; initialState = 8'h5A; genTarget = 8'd10;
    step("r204_load", 1'b1, 1'b0, 1'b0, 8'h5A, 8'd0, 1'b1, 1'b0, 1'b0);
`ifdef CA_STUCK_DETECT_EN
    step("r204_stuck", 1'b0, 1'b1, 1'b0, 8'h5A, 8'd1, 1'b0, 1'b1, 1'b1);
    step("r204_reload", 1'b1, 1'b0, 1'b0, 8'h5A, 8'd0, 1'b1, 1'b0, 1'b0);
`else
    for (int g = 1; g <= 10; g++) begin
      step("r204_tick", 1'b0, 1'b1, 1'b0, 8'h5A, g[7:0], g != 10, g == 10, 1'b0);
    end
    step("r204_hold", 1'b0, 1'b1, 1'b0, 8'h5A, 8'd10, 1'b0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
